// File: rtl/ultrasonic_echo_emu.sv
// HC-SR04 sensor emulator: validates a trig pulse, waits out the burst delay,
// then answers with an Echo pulse whose width encodes the programmed distance.
module ultrasonic_echo_emu #(
   parameter int unsigned TRIG_MIN_CYC  = 500,
   parameter int unsigned BURST_DLY_CYC = 10000,
   parameter int unsigned CYC_PER_CM    = 2900,
   parameter int unsigned MAX_CM        = 400,
   parameter int unsigned TIMEOUT_CYC   = 1900000,
   parameter int unsigned HOLDOFF_CYC   = 500000
) (
   input  logic        clk_50M,
   input  logic        s_rst,
   input  logic        trig,
   input  logic [15:0] dist_cm,
   output logic        Echo,
   output logic        busy,
   output logic        short_trig,
   output logic        ignored_trig,
   output logic [15:0] ping_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_HOLD} state_t;

   state_t      state, state_n;
   logic [31:0] cnt, cnt_n;
   logic [31:0] len_q;
   logic        trig_p0, ts, ts_q;
   logic        ts_rise, ts_fall;
   logic        latch_en, ping_inc, short_n, ign_n;

   function automatic logic [31:0] echo_len_f(input logic [15:0] d);
      if (d != 16'd0 && 32'(d) <= 32'(MAX_CM))
         return 32'(d) * 32'(CYC_PER_CM);
      else
         return 32'(TIMEOUT_CYC);
   endfunction

   assign ts_rise = ts & ~ts_q;
   assign ts_fall = ~ts & ts_q;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      latch_en = 1'b0;
      ping_inc = 1'b0;
      short_n  = 1'b0;
      ign_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (ts_rise) begin
               state_n = S_TRIG;
               cnt_n   = 32'd1;
            end
         end
         S_TRIG: begin
            if (ts_fall) begin
               if (cnt >= 32'(TRIG_MIN_CYC)) begin
                  state_n  = S_BURST;
                  cnt_n    = 32'd0;
                  latch_en = 1'b1;
               end else begin
                  state_n = S_IDLE;
                  short_n = 1'b1;
               end
            end else if (ts && cnt < 32'(TRIG_MIN_CYC)) begin
               cnt_n = cnt + 32'd1;
            end
         end
         S_BURST: begin
            // Echo is a flop loaded from state_n, so leave one cycle early to land
            // the rising edge exactly BURST_DLY_CYC cycles after the fall cycle.
            ign_n = ts_rise;
            if (cnt == 32'(BURST_DLY_CYC) - 32'd2) begin
               state_n = S_ECHO;
               cnt_n   = 32'd1;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         S_ECHO: begin
            ign_n = ts_rise;
            if (cnt == len_q) begin
               state_n  = S_HOLD;
               cnt_n    = 32'd1;
               ping_inc = 1'b1;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         S_HOLD: begin
            ign_n = ts_rise;
            if (cnt == 32'(HOLDOFF_CYC)) begin
               state_n = S_IDLE;
               cnt_n   = 32'd0;
            end else begin
               cnt_n = cnt + 32'd1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = 32'd0;
         end
      endcase
   end

   // stage p0/p1: trig synchronizer and edge-detect history, then FSM and registered outputs
   always_ff @(posedge clk_50M or posedge s_rst) begin
      if (s_rst) begin
         trig_p0      <= 1'b0;
         ts           <= 1'b0;
         ts_q         <= 1'b0;
         state        <= S_IDLE;
         cnt          <= 32'd0;
         Echo         <= 1'b0;
         busy         <= 1'b0;
         short_trig   <= 1'b0;
         ignored_trig <= 1'b0;
         ping_cnt     <= 16'd0;
      end else begin
         trig_p0      <= trig;
         ts           <= trig_p0;
         ts_q         <= ts;
         state        <= state_n;
         cnt          <= cnt_n;
         Echo         <= (state_n == S_ECHO);
         busy         <= (state_n != S_IDLE);
         short_trig   <= short_n;
         ignored_trig <= ign_n;
         if (ping_inc)
            ping_cnt <= ping_cnt + 16'd1;
      end
   end

   // echo length is data: loaded only at an accepted trig fall
   always_ff @(posedge clk_50M) begin
      if (latch_en)
         len_q <= echo_len_f(dist_cm);
   end

endmodule

// File: tb/tb_ultrasonic_echo_emu.sv
// Randomized bench for ultrasonic_echo_emu using small simulation parameters.
module tb_ultrasonic_echo_emu;

   localparam int TMIN = 10;
   localparam int DLY  = 20;
   localparam int CPC  = 4;
   localparam int MAXC = 400;
   localparam int TOUT = 2000;
   localparam int HOLD = 50;

   logic        clk_50M = 1'b0;
   logic        s_rst   = 1'b1;
   logic        trig    = 1'b0;
   logic [15:0] dist_cm = 16'd0;
   logic        Echo, busy, short_trig, ignored_trig;
   logic [15:0] ping_cnt;

   ultrasonic_echo_emu #(
      .TRIG_MIN_CYC (TMIN), .BURST_DLY_CYC(DLY), .CYC_PER_CM(CPC),
      .MAX_CM       (MAXC), .TIMEOUT_CYC (TOUT), .HOLDOFF_CYC(HOLD)
   ) dut (
      .clk_50M     (clk_50M),
      .s_rst       (s_rst),
      .trig        (trig),
      .dist_cm     (dist_cm),
      .Echo        (Echo),
      .busy        (busy),
      .short_trig  (short_trig),
      .ignored_trig(ignored_trig),
      .ping_cnt    (ping_cnt)
   );

   always #5 clk_50M = ~clk_50M;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int exp_ping = 0;

   // observation of output waveforms, cycle-stamped
   int echo_rise_cyc = -1, busy_rise_cyc = -1, busy_fall_cyc = -1;
   int last_width = 0, run = 0, n_echo = 0, n_short = 0, n_ign = 0;
   logic echo_prev = 1'b0, busy_prev = 1'b0;

   always @(posedge clk_50M) cyc <= cyc + 1;

   always @(negedge clk_50M) begin
      if (Echo && !echo_prev) echo_rise_cyc = cyc;
      if (Echo) run++;
      if (!Echo && echo_prev) begin
         last_width = run;
         run = 0;
         n_echo++;
      end
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      if (!busy && busy_prev) busy_fall_cyc = cyc;
      if (short_trig === 1'b1) n_short++;
      if (ignored_trig === 1'b1) n_ign++;
      echo_prev = Echo;
      busy_prev = busy;
   end

   // reference: Echo width from distance
   function automatic int exp_len(input int d);
      return (d >= 1 && d <= MAXC) ? d * CPC : TOUT;
   endfunction

   task automatic send_trig(input int w, input int d, output int r, output int k);
      @(posedge clk_50M); #1;
      dist_cm = 16'(d);
      trig = 1'b1;
      r = cyc;
      repeat (w) @(posedge clk_50M);
      #1 trig = 1'b0;
      k = cyc;
   endtask

   task automatic wait_idle(output bit ok);
      int n = 0;
      repeat (4) @(posedge clk_50M);
      while (busy && n < 5000) begin
         @(negedge clk_50M);
         n++;
      end
      ok = !busy;
      #2;
   endtask

   task automatic wait_echo(input logic lvl, output bit ok);
      int n = 0;
      while (Echo !== lvl && n < 5000) begin
         @(negedge clk_50M);
         n++;
      end
      ok = (Echo === lvl);
      #2;
   endtask

   task automatic test_reset;
      s_rst = 1'b1;
      repeat (3) @(posedge clk_50M);
      #1;
      checks++;
      if ({Echo, busy, short_trig, ignored_trig} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000", {Echo, busy, short_trig, ignored_trig});
      end
      checks++;
      if (ping_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_ping: got %0d expected 0", ping_cnt);
      end
      s_rst = 1'b0;
      repeat (3) @(posedge clk_50M);
   endtask

   // full accepted ping with every timing relation checked
   task automatic check_ping(input string tag, input int w, input int d);
      int r, k, len, ne;
      bit ok;
      len = exp_len(d);
      ne = n_echo;
      send_trig(w, d, r, k);
      wait_idle(ok);
      exp_ping++;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_timeout: busy still %b, expected 0", tag, busy);
      end
      checks++;
      if (last_width !== len || n_echo !== ne + 1) begin
         errors++;
         $display("FAIL %s_width: got %0d (pulses %0d) expected %0d (pulses %0d)", tag, last_width, n_echo - ne, len, 1);
      end
      checks++;
      if (echo_rise_cyc !== k + 2 + DLY) begin
         errors++;
         $display("FAIL %s_rise: got cyc %0d expected %0d", tag, echo_rise_cyc, k + 2 + DLY);
      end
      checks++;
      if (busy_rise_cyc !== r + 3 || busy_fall_cyc !== k + 2 + DLY + len + HOLD) begin
         errors++;
         $display("FAIL %s_busy: got %0d..%0d expected %0d..%0d", tag, busy_rise_cyc, busy_fall_cyc, r + 3, k + 2 + DLY + len + HOLD);
      end
      checks++;
      if (ping_cnt !== 16'(exp_ping)) begin
         errors++;
         $display("FAIL %s_ping: got %0d expected %0d", tag, ping_cnt, exp_ping);
      end
   endtask

   task automatic check_short(input string tag, input int w);
      int r, k, ns, ne;
      bit ok;
      ns = n_short;
      ne = n_echo;
      send_trig(w, $urandom_range(1, 400), r, k);
      wait_idle(ok);
      repeat (DLY + 10) @(posedge clk_50M);
      #1;
      checks++;
      if (n_short !== ns + 1 || n_echo !== ne) begin
         errors++;
         $display("FAIL %s_short: got short=%0d echo=%0d expected short=1 echo=0", tag, n_short - ns, n_echo - ne);
      end
      checks++;
      if (busy_fall_cyc !== k + 3 || ping_cnt !== 16'(exp_ping)) begin
         errors++;
         $display("FAIL %s_busyfall: got cyc %0d ping %0d expected cyc %0d ping %0d", tag, busy_fall_cyc, ping_cnt, k + 3, exp_ping);
      end
   endtask

   task automatic test_basic;
      check_ping("basic", 12, 25);
   endtask

   task automatic test_short_trig;
      check_short("short9", 9);
      check_short("short1", 1);
   endtask

   task automatic test_range;
      check_ping("dist0", 12, 0);
      check_ping("dist401", 12, 401);
      check_ping("dist400", 12, 400);
      check_ping("dist1", 10, 1);
   endtask

   task automatic test_ignored;
      int r, k, d, ni;
      bit ok, ok2, ok3;
      d = $urandom_range(50, 100);
      ni = n_ign;
      send_trig(12, d, r, k);
      wait_echo(1'b1, ok);
      repeat (10) @(posedge clk_50M);
      #1 trig = 1'b1;
      repeat (5) @(posedge clk_50M);
      #1 trig = 1'b0;
      wait_echo(1'b0, ok2);
      @(posedge clk_50M); #1 trig = 1'b1;
      repeat (5) @(posedge clk_50M);
      #1 trig = 1'b0;
      wait_idle(ok3);
      exp_ping++;
      checks++;
      if (!(ok && ok2 && ok3)) begin
         errors++;
         $display("FAIL ignored_timeout: got flags %b%b%b expected 111", ok, ok2, ok3);
      end
      checks++;
      if (n_ign !== ni + 2) begin
         errors++;
         $display("FAIL ignored_count: got %0d expected 2", n_ign - ni);
      end
      checks++;
      if (last_width !== exp_len(d) || ping_cnt !== 16'(exp_ping)) begin
         errors++;
         $display("FAIL ignored_width: got %0d ping %0d expected %0d ping %0d", last_width, ping_cnt, exp_len(d), exp_ping);
      end
      check_ping("after_hold", 12, $urandom_range(1, 400));
   endtask

   task automatic test_dist_change;
      int r, k, d;
      bit ok;
      d = $urandom_range(10, 200);
      send_trig(12, d, r, k);
      repeat (4) @(posedge clk_50M);
      #1 dist_cm = 16'(d + 37);
      wait_idle(ok);
      exp_ping++;
      checks++;
      if (!ok || last_width !== exp_len(d)) begin
         errors++;
         $display("FAIL dist_change: got %0d expected %0d", last_width, exp_len(d));
      end
   endtask

   task automatic test_random;
      int d, w, sel;
      for (int i = 0; i < 6; i++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) d = 0;
         else if (sel == 1) d = $urandom_range(401, 600);
         else d = $urandom_range(1, 400);
         if ($urandom_range(0, 3) == 0) check_short("rnd_short", $urandom_range(1, TMIN - 1));
         else check_ping("rnd", $urandom_range(TMIN, TMIN + 8), d);
      end
   endtask

   task automatic test_reset_mid_echo;
      int r, k;
      bit ok;
      send_trig(12, 200, r, k);
      wait_echo(1'b1, ok);
      repeat (30) @(posedge clk_50M);
      #3 s_rst = 1'b1;
      #1;
      exp_ping = 0;
      checks++;
      if (!ok || Echo !== 1'b0 || busy !== 1'b0 || ping_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid_echo: got echo=%b busy=%b ping=%0d expected 0 0 0", Echo, busy, ping_cnt);
      end
      repeat (3) @(posedge clk_50M);
      #1 s_rst = 1'b0;
      repeat (3) @(posedge clk_50M);
      check_ping("post_rst", 12, 3);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_trig();
      test_range();
      test_ignored();
      test_dist_change();
      test_random();
      test_reset_mid_echo();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
